// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the 7-segment scan multiplexer.
package seg_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    // Width of a digit index; a single-digit display still needs one bit.
    function automatic int idx_width(input int num_digits);
        return (num_digits <= 1) ? 1 : $clog2(num_digits);
    endfunction

    // With no blanking gap every slot starts directly in the drive phase.
    function automatic scan_state_e slot_start_state(input int blank_cycles);
        return (blank_cycles > 0) ? S_BLANK : S_DRIVE;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot sequencer: blank gap, dwell counter and digit index for the scan.
module seg_scan_timer
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 1,
    parameter int BRIGHT_W     = 3,
    localparam int IDX_W       = idx_width(NUM_DIGITS)
) (
    input  logic                clk_7seg,
    input  logic                rst_n,
    output scan_state_e         state,
    output logic [BRIGHT_W-1:0] dwell,
    output logic [IDX_W-1:0]    active_digit,
    output logic                slot_wrap
);

    localparam int BC_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BC_W-1:0]     BLANK_LAST = (BLANK_CYCLES > 0) ? BC_W'(BLANK_CYCLES - 1) : '0;
    localparam logic [BRIGHT_W-1:0] DWELL_LAST = '1;
    localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_e         START_ST   = slot_start_state(BLANK_CYCLES);

    scan_state_e         state_q, state_nxt;
    logic [BC_W-1:0]     blank_q, blank_nxt;
    logic [BRIGHT_W-1:0] dwell_q, dwell_nxt;
    logic [IDX_W-1:0]    idx_q, idx_nxt;

    always_ff @(posedge clk_7seg or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= START_ST;
            blank_q <= '0;
            dwell_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_nxt;
            blank_q <= blank_nxt;
            dwell_q <= dwell_nxt;
            idx_q   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        blank_nxt = blank_q;
        dwell_nxt = dwell_q;
        idx_nxt   = idx_q;
        case (state_q)
            S_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    state_nxt = S_DRIVE;
                    blank_nxt = '0;
                    dwell_nxt = '0;
                end else begin
                    blank_nxt = blank_q + 1'b1;
                end
            end
            S_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    // Explicit wrap keeps non-power-of-2 digit counts in range.
                    idx_nxt   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                    dwell_nxt = '0;
                    blank_nxt = '0;
                    state_nxt = START_ST;
                end else begin
                    dwell_nxt = dwell_q + 1'b1;
                end
            end
            default: state_nxt = START_ST;
        endcase
    end

    assign state        = state_q;
    assign dwell        = dwell_q;
    assign active_digit = idx_q;
    assign slot_wrap    = (state_q == S_DRIVE) && (dwell_q == DWELL_LAST) && (idx_q == IDX_LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 7-segment driver with frame-latched data and PWM brightness.
// Optional blinking is built when SEG_SCAN_BLINK_EN is defined.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS         = 8,
    parameter int SEG_WIDTH          = 7,
    parameter int BLANK_CYCLES       = 1,
    parameter int BRIGHT_W           = 3,
    parameter int ANODE_ACTIVE_LOW   = 1,
    parameter int CATHODE_ACTIVE_LOW = 1,
`ifdef SEG_SCAN_BLINK_EN
    parameter int BLINK_FRAMES       = 32,
`endif
    localparam int IDX_W             = idx_width(NUM_DIGITS)
) (
    input  logic                            clk_7seg,
    input  logic                            rst_n,
    input  logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]           digit_en,
    input  logic [BRIGHT_W-1:0]             brightness,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]           blink_mask,
`endif
    output logic [NUM_DIGITS-1:0]           anodes_7seg,
    output logic [SEG_WIDTH-1:0]            cathodes_7seg,
    output logic [IDX_W-1:0]                active_digit,
    output logic                            frame_done
);

    scan_state_e         state;
    logic [BRIGHT_W-1:0] dwell;
    logic                slot_wrap;

    logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_lat;
    logic [NUM_DIGITS-1:0]           en_lat;
    logic [BRIGHT_W-1:0]             bri_lat;

    logic [NUM_DIGITS-1:0] anode_on;
    logic [SEG_WIDTH-1:0]  seg_sel;
    logic [SEG_WIDTH-1:0]  seg_on;

    seg_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BRIGHT_W     (BRIGHT_W)
    ) u_timer (
        .clk_7seg     (clk_7seg),
        .rst_n        (rst_n),
        .state        (state),
        .dwell        (dwell),
        .active_digit (active_digit),
        .slot_wrap    (slot_wrap)
    );

    // Inputs are only sampled on the frame wrap so a frame never shows mixed data.
    always_ff @(posedge clk_7seg or negedge rst_n) begin
        if (!rst_n) begin
            seg_lat    <= '0;
            en_lat     <= '0;
            bri_lat    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= slot_wrap;
            if (slot_wrap) begin
                seg_lat <= seg_in;
                en_lat  <= digit_en;
                bri_lat <= brightness;
            end
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [NUM_DIGITS-1:0] blink_lat;
    logic [FC_W-1:0]       frame_cnt;
    logic                  blink_phase;

    always_ff @(posedge clk_7seg or negedge rst_n) begin
        if (!rst_n) begin
            blink_lat   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (slot_wrap) begin
            blink_lat <= blink_mask;
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`endif

    // Decode uses registered state and latched data only, never the live inputs.
    always_comb begin
        anode_on = '0;
        seg_sel  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (active_digit == IDX_W'(k)) begin
                seg_sel = seg_lat[k*SEG_WIDTH +: SEG_WIDTH];
`ifdef SEG_SCAN_BLINK_EN
                anode_on[k] = (state == S_DRIVE) && en_lat[k] && (dwell <= bri_lat)
                              && !(blink_phase && blink_lat[k]);
`else
                anode_on[k] = (state == S_DRIVE) && en_lat[k] && (dwell <= bri_lat);
`endif
            end
        end
        seg_on = (state == S_DRIVE) ? seg_sel : '0;
    end

    assign anodes_7seg   = (ANODE_ACTIVE_LOW != 0)   ? ~anode_on : anode_on;
    assign cathodes_7seg = (CATHODE_ACTIVE_LOW != 0) ? ~seg_on   : seg_on;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomised bench for seg_scan_mux against a cycle-count based display model.
module tb_seg_scan_mux;

    localparam int ND    = 8;
    localparam int SW    = 7;
    localparam int BC    = 1;
    localparam int DRV   = 8;
    localparam int SLOT  = BC + DRV;
    localparam int FRAME = ND * SLOT;

    logic            clk_7seg = 1'b0;
    logic            rst_n;
    logic [ND*SW-1:0] seg_in;
    logic [ND-1:0]   digit_en;
    logic [2:0]      brightness;
    logic [ND-1:0]   anodes_7seg;
    logic [SW-1:0]   cathodes_7seg;
    logic [2:0]      active_digit;
    logic            frame_done;
`ifdef SEG_SCAN_BLINK_EN
    logic [ND-1:0]   blink_mask = '0;
`endif

    seg_scan_mux dut (
        .clk_7seg      (clk_7seg),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .digit_en      (digit_en),
        .brightness    (brightness),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask    (blink_mask),
`endif
        .anodes_7seg   (anodes_7seg),
        .cathodes_7seg (cathodes_7seg),
        .active_digit  (active_digit),
        .frame_done    (frame_done)
    );

    always #5 clk_7seg = ~clk_7seg;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles since reset release plus the values captured at each frame end.
    int          n;
    logic [ND*SW-1:0] seg_m;
    logic [ND-1:0]    en_m;
    logic [2:0]       bri_m;
    bit               rnd_en;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string when);
        check_val({when, " anodes"},       64'(anodes_7seg),   64'hFF);
        check_val({when, " cathodes"},     64'(cathodes_7seg), 64'h7F);
        check_val({when, " active_digit"}, 64'(active_digit),  64'd0);
        check_val({when, " frame_done"},   64'(frame_done),    64'd0);
    endtask

    task automatic check_cycle();
        int pos, slot, sub;
        bit drive, on;
        logic [ND-1:0] exp_an;
        logic [SW-1:0] exp_ca;
        pos   = n % FRAME;
        slot  = pos / SLOT;
        sub   = pos % SLOT;
        drive = (sub >= BC);
        on    = drive && en_m[slot] && ((sub - BC) <= int'(bri_m));
        exp_an = on ? ~(8'd1 << slot) : 8'hFF;
        exp_ca = drive ? ~seg_m[slot*SW +: SW] : 7'h7F;
        check_val($sformatf("anodes c%0d", n),       64'(anodes_7seg),   64'(exp_an));
        check_val($sformatf("cathodes c%0d", n),     64'(cathodes_7seg), 64'(exp_ca));
        check_val($sformatf("active_digit c%0d", n), 64'(active_digit),  64'(slot));
        check_val($sformatf("frame_done c%0d", n),   64'(frame_done),    64'((n >= FRAME) && (pos == 0)));
    endtask

    task automatic randomize_inputs();
        logic [63:0] r;
        r          = {$urandom(), $urandom()};
        seg_in     = r[ND*SW-1:0];
        digit_en   = 8'($urandom());
        brightness = 3'($urandom_range(0, 7));
    endtask

    task automatic model_reset();
        n     = 0;
        seg_m = '0;
        en_m  = '0;
        bri_m = '0;
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(negedge clk_7seg);
            check_cycle();
            if (rnd_en && ($urandom_range(0, 15) == 0)) randomize_inputs();
            @(posedge clk_7seg);
            if ((n % FRAME) == FRAME - 1) begin
                seg_m = seg_in;
                en_m  = digit_en;
                bri_m = brightness;
            end
            n++;
            #1;
        end
    endtask

    initial begin
        rnd_en     = 1'b0;
        rst_n      = 1'b0;
        seg_in     = '0;
        digit_en   = '0;
        brightness = '0;
        model_reset();
        repeat (3) @(posedge clk_7seg);
        #1;
        check_reset_outputs("reset");

        for (int k = 0; k < ND; k++) seg_in[k*SW +: SW] = 7'(7'h10 + k);
        seg_in[3*SW +: SW] = 7'h06;
        digit_en   = 8'hFF;
        brightness = 3'd7;
        #1;
        rst_n = 1'b1;

        // Frame 0 shows reset-latched blank data; frame 1 full brightness.
        run_cycles(FRAME);
        run_cycles(30);
        seg_in[3*SW +: SW] = 7'h5B;
        brightness = 3'd2;
        run_cycles(FRAME - 30);
        run_cycles(FRAME);

        digit_en   = 8'hAA;
        brightness = 3'd0;
        run_cycles(FRAME);
        run_cycles(FRAME);

        rnd_en = 1'b1;
        run_cycles(6 * FRAME);

        // Asynchronous reset in the middle of a frame, checked before any clock edge.
        run_cycles(37);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        repeat (2) @(posedge clk_7seg);
        #2;
        model_reset();
        rst_n = 1'b1;
        run_cycles(3 * FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Parametrised time-multiplexed driver for N common-anode/common-cathode 7-segment digits (optional decimal point).
- Scans digits in a fixed order and inserts an anti-ghosting blanking gap between digits.
- Provides per-digit PWM brightness, per-digit enable, and tear-free frame-latched display data.
- Sits between display-content logic and the board pins; clocked by the slow scan clock clk_7seg.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (>=1).
- SEG_WIDTH, 7: segment lines per digit (7, or 8 with DP).
- BLANK_CYCLES, 1: all-anodes-off cycles before each digit slot (0 allowed = no blanking).
- BRIGHT_W, 3: brightness width; DRIVE phase lasts 2**BRIGHT_W cycles.
- ANODE_ACTIVE_LOW, 1: 1 = anode asserted by driving 0.
- CATHODE_ACTIVE_LOW, 1: 1 = segment lit by driving 0.

Ports:
- rst_n  in  1  Reset: asynchronous, active-low.
- clk_7seg  in  1  Scan clock.
- seg_in  in  NUM_DIGITS*SEG_WIDTH  Logical segment data, 1 = lit; digit k at bits [k*SEG_WIDTH +: SEG_WIDTH].
- digit_en  in  NUM_DIGITS  Per-digit enable.
- brightness  in  BRIGHT_W  Global brightness.
- anodes_7seg  out  NUM_DIGITS  Physical anode drive.
- cathodes_7seg  out  SEG_WIDTH  Physical segment drive.
- active_digit  out  IDX_W  Index of current slot; IDX_W = max(1, $clog2(NUM_DIGITS)).
- frame_done  out  1  One-cycle pulse at start of each frame.

Behaviour:
- Reset (async): the following take effect immediately, without a clock edge.
  - State S_BLANK, digit index 0, counters 0.
  - Latched seg/en/brightness registers all 0.
  - Anodes all inactive; cathodes all inactive; active_digit 0; frame_done 0.
- Slot structure: each digit slot = BLANK_CYCLES cycles of S_BLANK, then 2**BRIGHT_W cycles of S_DRIVE (dwell counter 0..2**BRIGHT_W-1).
  - If BLANK_CYCLES==0, S_BLANK is never entered.
  - Frame period = NUM_DIGITS*(BLANK_CYCLES + 2**BRIGHT_W) cycles.
- Transitions:
  - S_BLANK → S_DRIVE when blank count reaches BLANK_CYCLES-1.
  - S_DRIVE last cycle → next digit slot. Index increments, wrapping NUM_DIGITS-1 → 0; no illegal index states for non-power-of-2 counts.
- Frame latch: on the wrap edge (last DRIVE cycle of digit NUM_DIGITS-1), seg_in, digit_en and brightness are captured.
  - Input changes at any other time have no visible effect until the next wrap.
  - The first frame after reset displays the reset-latched values, i.e. all blank.
- frame_done: high for exactly the one cycle following each wrap edge, i.e. the first cycle of digit 0's slot. Not asserted in the first frame after reset.
- Outputs are combinational decodes of registered state and latched data only; no input-to-output combinational path.
- Anode k is asserted iff all of:
  - state == S_DRIVE;
  - active_digit == k;
  - latched digit_en[k] == 1;
  - dwell count <= latched brightness.
  - Consequence: brightness 0 = 1 on-cycle per slot; maximum = full DRIVE.
- Cathodes carry the latched segment pattern for active_digit during S_DRIVE and are inactive during S_BLANK. Polarity is applied per CATHODE_ACTIVE_LOW; anode polarity per ANODE_ACTIVE_LOW.
- Disabled digits keep their slot time; scan timing never depends on data.
- Reset mid-scan: outputs go inactive immediately. After release, scanning restarts at digit 0 S_BLANK (or S_DRIVE if BLANK_CYCLES==0).

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds parameter BLINK_FRAMES (default 32) and input blink_mask [NUM_DIGITS]. blink_mask is latched with the other inputs on the wrap edge.
  - A frame counter toggles blink_phase every BLINK_FRAMES frames; blink_phase is 0 after reset.
  - While blink_phase==1, anodes of digits with latched blink_mask set are held inactive.
- Undefined: no port, parameter, counter or gating logic.

Decomposition:
- Package seg_scan_pkg: enum scan_state_e {S_BLANK, S_DRIVE}; helper function returning the index width IDX_W from NUM_DIGITS.
- Sub-module seg_scan_timer: owns the state, blank/dwell counters and digit index; outputs state, dwell count, active_digit and slot_wrap.
- The top level owns the frame latch, gating, polarity and blink logic.

Test Plan:
- Reset: hold rst_n=0 with defaults → anodes 8'hFF, cathodes 7'h7F, frame_done 0; after release the first frame is all blank.
- Scan order, defaults with brightness=7, all enabled → per slot 1 cycle anodes=8'hFF then 8 cycles anodes=~(1<<k), k=0..7; frame_done every 72 cycles.
- Brightness=2 latched → anode active for DRIVE cycles 0–2 only, inactive for cycles 3–7 of each slot.
- Tear-free: change seg_in digit 3 from 7'h06 to 7'h5B mid-frame → cathodes on digit 3 show ~7'h06 until after the next frame_done, then ~7'h5B.
- digit_en=8'hAA → digits 0,2,4,6 never asserted, slot timing unchanged; NUM_DIGITS=6 build wraps 5→0.
- SEG_SCAN_BLINK_EN with BLINK_FRAMES=2, blink_mask=8'h01 → digit 0 lit in frames 0–1, dark in frames 2–3, repeating; other digits unaffected.
